cpu_reset_sequencer: RTL and testbench
======================================

CPU_RESET_SEQUENCER -- requirements
Module: cpu_reset_sequencer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of flops in the pll_locked synchronizer (minimum 2).
REQ-002 SHALL have parameter HOLD_CYCLES, default 16, number of cycles lock must be stable before memory reset release (minimum 1).
REQ-003 SHALL have parameter MEM_LEAD, default 8, number of cycles between mem_rst release and cpu_rst release (minimum 1).
REQ-004 SHALL have port clk, input, 1, 40 MHz CPU clock from the PLL output; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port pll_locked, input, 1, PLL lock indication; asynchronous to clk.
REQ-007 SHALL have port soft_rst_req, input, 1, synchronous single-cycle CPU-only reset request (watchdog/debug).
REQ-008 SHALL have port mem_rst, output, 1, active-high reset to memory/bus fabric; registered.
REQ-009 SHALL have port cpu_rst, output, 1, active-high reset to CPU core; registered.
REQ-010 SHALL have port ready, output, 1, high only in state RUN; registered.
REQ-011 SHALL have port lock_loss_cnt, output, 8, saturating count of lock losses since rst; registered.

Function
REQ-012 SHALL pass pll_locked through a SYNC_STAGES flop chain; locked_s is the final flop, and no other logic samples pll_locked directly.
REQ-013 SHALL implement states WAIT_LOCK, HOLD, MEM_UP, RUN, SOFT with a single cycle counter cnt sized for max(HOLD_CYCLES, MEM_LEAD).
REQ-014 In WAIT_LOCK (mem_rst=1, cpu_rst=1, ready=0): when locked_s=1, SHALL go to HOLD with cnt=0.
REQ-015 In HOLD (mem_rst=1, cpu_rst=1): SHALL increment cnt each cycle; when cnt==HOLD_CYCLES-1 and locked_s=1, SHALL go to MEM_UP with cnt=0 and mem_rst=0 on that edge.
REQ-016 In MEM_UP (mem_rst=0, cpu_rst=1): SHALL increment cnt; when cnt==MEM_LEAD-1, SHALL go to RUN with cpu_rst=0 and ready=1 on that edge.
REQ-017 In RUN (all resets 0, ready=1): soft_rst_req=1 SHALL go to SOFT with cnt=0, cpu_rst=1, ready=0 on the next edge, with mem_rst staying 0.
REQ-018 In SOFT: SHALL increment cnt; at cnt==HOLD_CYCLES-1 SHALL return to RUN (cpu_rst=0, ready=1); soft_rst_req in SOFT SHALL be ignored (no restart of cnt).
REQ-019 soft_rst_req SHALL be ignored in WAIT_LOCK, HOLD and MEM_UP.
REQ-020 In any state other than WAIT_LOCK, locked_s=0 SHALL have priority over all other conditions: next edge goes to WAIT_LOCK with mem_rst=1, cpu_rst=1, ready=0, cnt=0.
REQ-021 lock_loss_cnt SHALL increment by 1 on each transition into WAIT_LOCK caused by REQ-020, from MEM_UP, RUN or SOFT only, and SHALL saturate at 255.
REQ-022 Simultaneous locked_s=0 and soft_rst_req=1 in RUN SHALL take the WAIT_LOCK path and increment lock_loss_cnt once.
REQ-023 End-to-end timing: with pll_locked steady high, mem_rst SHALL fall SYNC_STAGES+HOLD_CYCLES+1 edges after the first edge sampling pll_locked=1, and cpu_rst SHALL fall MEM_LEAD edges after mem_rst.
REQ-024 cpu_rst SHALL never be 0 while mem_rst is 1.
REQ-025 No output SHALL glitch; every output SHALL be driven directly from a flop.

Reset
REQ-026 On rst=1 at a clk edge, the block SHALL set state=WAIT_LOCK, mem_rst=1, cpu_rst=1, ready=0, cnt=0, lock_loss_cnt=0 and clear all sync flops to 0, regardless of the current state.
REQ-027 While rst=1, outputs SHALL hold their reset values; sequencing SHALL restart from WAIT_LOCK after rst falls, even if pll_locked is already 1.

Verification
REQ-028 Power-up check: rst high 4 cycles, then pll_locked=1 steady (defaults) -> mem_rst falls at edge 19, cpu_rst and ready change at edge 27, lock_loss_cnt=0.
REQ-029 Glitch check: pll_locked drops at HOLD cnt=10 -> WAIT_LOCK, mem_rst stays 1, lock_loss_cnt stays 0; full 16-cycle hold restarts after relock.
REQ-030 Soft reset check: soft_rst_req 1-cycle pulse in RUN -> cpu_rst=1 and ready=0 for exactly 16 cycles, mem_rst stays 0; a second pulse during SOFT has no effect.
REQ-031 Lock loss in RUN: pll_locked=0 -> both resets 1 within SYNC_STAGES+1 edges, lock_loss_cnt 0->1; repeat 300 times -> lock_loss_cnt=255.
REQ-032 Simultaneous events: locked_s=0 and soft_rst_req=1 in the same RUN cycle -> WAIT_LOCK, lock_loss_cnt incremented exactly once.
REQ-033 Reset mid-operation: rst asserted in MEM_UP -> next edge mem_rst=1, cpu_rst=1, lock_loss_cnt=0; full sequence re-runs after rst releases.

Source files
------------

// File: rtl/cpu_reset_sequencer.sv
// ============================================================================
//  Module      : cpu_reset_sequencer
//  Description : Orders memory/CPU reset release behind a stable, synchronized
//                PLL lock, with a CPU-only soft reset and a lock-loss counter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module cpu_reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int MEM_LEAD    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       soft_rst_req,
  output logic       mem_rst,
  output logic       cpu_rst,
  output logic       ready,
  output logic [7:0] lock_loss_cnt
);

  localparam int C_CNT_MAX = (HOLD_CYCLES > MEM_LEAD) ? HOLD_CYCLES : MEM_LEAD;
  localparam int C_CNT_W   = (C_CNT_MAX > 1) ? $clog2(C_CNT_MAX) : 1;

  localparam logic [C_CNT_W-1:0] C_HOLD_LAST = C_CNT_W'(HOLD_CYCLES - 1);
  localparam logic [C_CNT_W-1:0] C_LEAD_LAST = C_CNT_W'(MEM_LEAD - 1);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE   = C_CNT_W'(1);

  localparam logic [2:0] S_WAIT_LOCK = 3'd0;
  localparam logic [2:0] S_HOLD      = 3'd1;
  localparam logic [2:0] S_MEM_UP    = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_SOFT      = 3'd4;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_locked_s;

  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;
  logic [C_CNT_W-1:0] r_cnt;
  logic [C_CNT_W-1:0] w_cnt_nxt;
  logic               w_loss_evt;

  logic       r_mem_rst;
  logic       r_cpu_rst;
  logic       r_ready;
  logic [7:0] r_loss_cnt;
  logic       w_mem_rst_nxt;
  logic       w_cpu_rst_nxt;
  logic       w_ready_nxt;

  // pll_locked is asynchronous; only the last flop of this chain is used.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign w_locked_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_WAIT_LOCK;
      r_cnt      <= '0;
      r_mem_rst  <= 1'b1;
      r_cpu_rst  <= 1'b1;
      r_ready    <= 1'b0;
      r_loss_cnt <= 8'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_mem_rst <= w_mem_rst_nxt;
      r_cpu_rst <= w_cpu_rst_nxt;
      r_ready   <= w_ready_nxt;
      if (w_loss_evt && (r_loss_cnt != 8'hFF)) begin
        r_loss_cnt <= r_loss_cnt + 8'd1;
      end
    end
  end

  // Lock loss outranks everything, including a coincident soft reset request.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_loss_evt  = 1'b0;
    if ((r_state != S_WAIT_LOCK) && !w_locked_s) begin
      w_state_nxt = S_WAIT_LOCK;
      w_cnt_nxt   = '0;
      w_loss_evt  = (r_state == S_MEM_UP) || (r_state == S_RUN) || (r_state == S_SOFT);
    end else begin
      case (r_state)
        S_WAIT_LOCK: begin
          if (w_locked_s) begin
            w_state_nxt = S_HOLD;
            w_cnt_nxt   = '0;
          end
        end
        S_HOLD: begin
          if (r_cnt == C_HOLD_LAST) begin
            w_state_nxt = S_MEM_UP;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + C_CNT_ONE;
          end
        end
        S_MEM_UP: begin
          if (r_cnt == C_LEAD_LAST) begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + C_CNT_ONE;
          end
        end
        S_RUN: begin
          if (soft_rst_req) begin
            w_state_nxt = S_SOFT;
            w_cnt_nxt   = '0;
          end
        end
        S_SOFT: begin
          if (r_cnt == C_HOLD_LAST) begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + C_CNT_ONE;
          end
        end
        default: begin
          w_state_nxt = S_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so each one lands in its own flop.
  always_comb begin
    w_mem_rst_nxt = (w_state_nxt == S_WAIT_LOCK) || (w_state_nxt == S_HOLD);
    w_cpu_rst_nxt = (w_state_nxt != S_RUN);
    w_ready_nxt   = (w_state_nxt == S_RUN);
  end

  assign mem_rst       = r_mem_rst;
  assign cpu_rst       = r_cpu_rst;
  assign ready         = r_ready;
  assign lock_loss_cnt = r_loss_cnt;

endmodule

`default_nettype wire

// File: tb/tb_cpu_reset_sequencer.sv
// ============================================================================
//  Module      : tb_cpu_reset_sequencer
//  Description : Self-checking bench for cpu_reset_sequencer with a
//                lock-duration reference model and randomized stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/100ps

module tb_cpu_reset_sequencer;

  localparam int SYNC_STAGES = 2;
  localparam int HOLD_CYCLES = 16;
  localparam int MEM_LEAD    = 8;
  localparam int C_T_CAP     = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       soft_rst_req = 1'b0;
  logic       mem_rst;
  logic       cpu_rst;
  logic       ready;
  logic [7:0] lock_loss_cnt;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en   = 1'b0;

  cpu_reset_sequencer #(
    .SYNC_STAGES (SYNC_STAGES),
    .HOLD_CYCLES (HOLD_CYCLES),
    .MEM_LEAD    (MEM_LEAD)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .pll_locked    (pll_locked),
    .soft_rst_req  (soft_rst_req),
    .mem_rst       (mem_rst),
    .cpu_rst       (cpu_rst),
    .ready         (ready),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #12.5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: m_t counts consecutive edges with synchronized lock seen
  // since the last drop; resets release at fixed thresholds of m_t.
  logic [SYNC_STAGES-1:0] m_sync = '0;
  int m_t    = 0;
  int m_soft = 0;
  int m_loss = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_sync = '0;
      m_t    = 0;
      m_soft = 0;
      m_loss = 0;
    end else begin
      if (!m_sync[SYNC_STAGES-1]) begin
        if (m_t > HOLD_CYCLES && m_loss < 255) m_loss = m_loss + 1;
        m_t    = 0;
        m_soft = 0;
      end else begin
        if (m_soft > 0) m_soft = m_soft - 1;
        else if (m_t > HOLD_CYCLES + MEM_LEAD && soft_rst_req) m_soft = HOLD_CYCLES;
        if (m_t < C_T_CAP) m_t = m_t + 1;
      end
      m_sync = {m_sync[SYNC_STAGES-2:0], pll_locked};
    end
  end

  always @(negedge clk) begin
    logic exp_mem, exp_cpu;
    if (mon_en) begin
      exp_mem = (m_t <= HOLD_CYCLES);
      exp_cpu = (m_t <= HOLD_CYCLES + MEM_LEAD) || (m_soft > 0);
      check("mon_mem_rst", 32'(mem_rst), 32'(exp_mem));
      check("mon_cpu_rst", 32'(cpu_rst), 32'(exp_cpu));
      check("mon_ready", 32'(ready), 32'(!exp_cpu));
      check("mon_loss", 32'(lock_loss_cnt), 32'(m_loss));
      check("mon_order", 32'(!cpu_rst && mem_rst), 32'd0);
    end
  end

  // mode 0: until mem_rst falls; mode 1: until both resets are high.
  task automatic count_edges(input int mode, output int n);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if ((mode == 0 && !mem_rst) || (mode == 1 && mem_rst && cpu_rst)) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int k;
    bit ok;
    bit mem_ok;

    // Power-up
    repeat (4) @(posedge clk);
    @(negedge clk);
    mon_en     = 1'b1;
    rst        = 1'b0;
    pll_locked = 1'b1;
    for (int e = 1; e <= 27; e++) begin
      @(posedge clk);
      #1;
      if (e == 18) check("pwr_mem_e18", 32'(mem_rst), 32'd1);
      if (e == 19) check("pwr_mem_e19", 32'(mem_rst), 32'd0);
      if (e == 26) check("pwr_cpu_e26", 32'(cpu_rst), 32'd1);
      if (e == 27) begin
        check("pwr_cpu_e27", 32'(cpu_rst), 32'd0);
        check("pwr_ready_e27", 32'(ready), 32'd1);
        check("pwr_loss", 32'(lock_loss_cnt), 32'd0);
      end
    end

    // Glitch during HOLD
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (13) @(posedge clk);
    @(negedge clk); pll_locked = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch_mem", 32'(mem_rst), 32'd1);
    check("glitch_loss", 32'(lock_loss_cnt), 32'd0);
    pll_locked = 1'b1;
    count_edges(0, n);
    check("glitch_relock_edges", 32'(n), 32'(SYNC_STAGES + HOLD_CYCLES + 1));

    // Soft reset with a second ignored pulse
    wait_ready(ok);
    check("soft_reach_run", 32'(ok), 32'd1);
    soft_rst_req = 1'b1;
    @(negedge clk);
    soft_rst_req = 1'b0;
    k = 0;
    mem_ok = 1'b1;
    while (cpu_rst && k < 100) begin
      k++;
      soft_rst_req = (k == 5);
      if (mem_rst) mem_ok = 1'b0;
      @(negedge clk);
    end
    soft_rst_req = 1'b0;
    check("soft_len", 32'(k), 32'(HOLD_CYCLES));
    check("soft_mem_low", 32'(mem_ok), 32'd1);

    // Simultaneous lock loss and soft request in RUN
    wait_ready(ok);
    check("simul_reach_run", 32'(ok), 32'd1);
    pll_locked = 1'b0;
    @(negedge clk);
    @(negedge clk); soft_rst_req = 1'b1;
    @(negedge clk); soft_rst_req = 1'b0;
    check("simul_mem", 32'(mem_rst), 32'd1);
    check("simul_cpu", 32'(cpu_rst), 32'd1);
    check("simul_loss", 32'(lock_loss_cnt), 32'd1);

    // Reset asserted in MEM_UP
    pll_locked = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!mem_rst && cpu_rst) begin
        ok = 1'b1;
        break;
      end
    end
    check("rstmid_reach_memup", 32'(ok), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rstmid_mem", 32'(mem_rst), 32'd1);
    check("rstmid_cpu", 32'(cpu_rst), 32'd1);
    check("rstmid_loss", 32'(lock_loss_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    count_edges(0, n);
    check("rstmid_rerun_edges", 32'(n), 32'(SYNC_STAGES + HOLD_CYCLES + 1));

    // Repeated lock loss in RUN, counter saturation
    for (int i = 0; i < 300; i++) begin
      wait_ready(ok);
      if (!ok) begin
        check("loss_reach_run", 32'(ok), 32'd1);
        break;
      end
      pll_locked = 1'b0;
      count_edges(1, n);
      check("loss_latency", 32'(n), 32'(SYNC_STAGES + 1));
      if (i == 0) check("loss_first", 32'(lock_loss_cnt), 32'd1);
      @(negedge clk);
      pll_locked = 1'b1;
    end
    @(negedge clk);
    check("loss_saturate", 32'(lock_loss_cnt), 32'd255);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (pll_locked) pll_locked = ($urandom_range(0, 99) >= 2);
      else            pll_locked = ($urandom_range(0, 99) < 20);
      soft_rst_req = ($urandom_range(0, 19) == 0);
      rst          = ($urandom_range(0, 599) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    soft_rst_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #(25.0 * 60000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
